mem_stage_sram_ctrl: RTL and testbench

- MEM-stage consumer of the EXE-stage outputs (alu_result as address, val_rm_out as store data, mem_r_en/mem_w_en, wb_en, dest).
- Converts each 32-bit load/store into two sequential 16-bit accesses on an external asynchronous SRAM.
- Drives ready low while an access is in flight so the hazard/freeze logic can stall the pipeline.
- Presents the load result and pass-through control to the MEM/WB register.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 19 +
 rtl/mem_stage_sram_ctrl_if.sv | 22 ++
 rtl/mem_stage_sram_ctrl_phase_counter.sv | 24 ++
 rtl/mem_stage_sram_ctrl.sv | 104 ++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;
    localparam int MEM_BASE_DEF      = 1024;
    localparam int SRAM_AW_DEF       = 18;
    localparam int ACCESS_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

    function automatic logic is_write(state_t s);
        return (s == WR_LO) || (s == WR_HI);
    endfunction
endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pad-side bus of the external asynchronous 16-bit SRAM.
interface mem_stage_sram_ctrl_if
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW = SRAM_AW_DEF
);
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;

    modport master (
        output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
        output sram_dq_in
    );
endinterface

// File: rtl/mem_stage_sram_ctrl_phase_counter.sv
// Per-phase cycle counter: counts while enabled, restarts whenever the owning FSM changes state.
module mem_stage_sram_ctrl_phase_counter #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic last_o,
    output logic penult_o
);
    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d    = (!en_i || clr_i) ? '0 : cnt_q + CNT_W'(1);
    assign last_o   = (cnt_q == CNT_W'(CYCLES - 1));
    assign penult_o = (cnt_q == CNT_W'(CYCLES - 2));

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: splits each 32-bit load/store into two 16-bit SRAM phases and
// holds ready low while the access is in flight.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int MEM_BASE      = MEM_BASE_DEF,
    parameter int SRAM_AW       = SRAM_AW_DEF,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  dest_in,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic [3:0]  dest,
    output logic [31:0] alu_result,
    output logic [31:0] mem_read_value,
    output logic        ready,
    mem_stage_sram_ctrl_if.master sram
);
    localparam int WORD_W = SRAM_AW - 1;

    state_t             state_q, state_d;
    logic               we_n_q, we_n_d;
    logic               oe_q, oe_d;
    logic [31:0]        rd_q;
    logic               last, penult, cnt_en;
    logic [WORD_W-1:0]  word;
    logic [SRAM_AW-1:0] lo_addr, hi_addr;

    // Byte offset to halfword pair; upper bits fall off so addresses wrap.
    assign word    = WORD_W'((alu_result_in - 32'(MEM_BASE)) >> 2);
    assign lo_addr = {word, 1'b0};
    assign hi_addr = {word, 1'b1};
    assign cnt_en  = state_q inside {WR_LO, WR_HI, RD_LO, RD_HI};

    mem_stage_sram_ctrl_phase_counter #(.CYCLES(ACCESS_CYCLES)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en_i     (cnt_en),
        .clr_i    (state_d != state_q),
        .last_o   (last),
        .penult_o (penult)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_w_en_in)      state_d = WR_LO;
                     else if (mem_r_en_in) state_d = RD_LO;
            WR_LO:   if (last) state_d = WR_HI;
            WR_HI:   if (last) state_d = DONE;
            RD_LO:   if (last) state_d = RD_HI;
            RD_HI:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe is released for the final cycle of a write phase so address/data outlive it.
    assign we_n_d = !is_write(state_d) || ((state_d == state_q) && penult);
    assign oe_d   = is_write(state_d);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            we_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            we_n_q  <= we_n_d;
            oe_q    <= oe_d;
            if (state_q == RD_LO && last) rd_q[15:0]  <= sram.sram_dq_in;
            if (state_q == RD_HI && last) rd_q[31:16] <= sram.sram_dq_in;
        end
    end

    always_comb begin
        case (state_q)
            WR_LO:   sram.sram_dq_out = val_rm_in[15:0];
            WR_HI:   sram.sram_dq_out = val_rm_in[31:16];
            default: sram.sram_dq_out = '0;
        endcase
    end

    assign sram.sram_addr  = (state_q == WR_HI || state_q == RD_HI) ? hi_addr : lo_addr;
    assign sram.sram_we_n  = we_n_q;
    assign sram.sram_dq_oe = oe_q;

    assign ready = (state_q == DONE) ||
                   (state_q == IDLE && !mem_r_en_in && !mem_w_en_in);

    assign wb_en          = wb_en_in;
    assign mem_r_en       = mem_r_en_in;
    assign dest           = dest_in;
    assign alu_result     = alu_result_in;
    assign mem_read_value = rd_q;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed and random loads/stores against a cycle-indexed access model and an SRAM model.
module tb_mem_stage_sram_ctrl;
    localparam int AC   = 2;
    localparam int AW   = 18;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_result_in, val_rm_in;
    logic [3:0]  dest_in;
    logic        wb_en, mem_r_en, ready;
    logic [3:0]  dest;
    logic [31:0] alu_result, mem_read_value;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if #(.SRAM_AW(AW)) sram_bus ();

    mem_stage_sram_ctrl #(.MEM_BASE(BASE), .SRAM_AW(AW), .ACCESS_CYCLES(AC)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_en_in       (wb_en_in),
        .mem_r_en_in    (mem_r_en_in),
        .mem_w_en_in    (mem_w_en_in),
        .alu_result_in  (alu_result_in),
        .val_rm_in      (val_rm_in),
        .dest_in        (dest_in),
        .wb_en          (wb_en),
        .mem_r_en       (mem_r_en),
        .dest           (dest),
        .alu_result     (alu_result),
        .mem_read_value (mem_read_value),
        .ready          (ready),
        .sram           (sram_bus)
    );

    // Asynchronous SRAM: read is combinational, write lands when the strobe rises.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    always_comb sram_bus.sram_dq_in = sram_mem[sram_bus.sram_addr];

    initial begin
        logic          wp;
        logic [AW-1:0] pa;
        logic [15:0]   pd;
        wp = 1'b0;
        pa = '0;
        pd = '0;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
        forever begin
            @(negedge clk);
            if (!sram_bus.sram_we_n && sram_bus.sram_dq_oe) begin
                wp = 1'b1;
                pa = sram_bus.sram_addr;
                pd = sram_bus.sram_dq_out;
            end else if (wp) begin
                sram_mem[pa] = pd;
                wp = 1'b0;
            end
        end
    end

    int          tests = 0;
    int          fails = 0;
    int          we_low_cnt = 0;
    int          rdy_lo_cnt = 0;
    logic        exp_valid = 1'b0;
    logic        exp_ready, exp_we_n, exp_oe;
    logic [31:0] exp_addr, exp_dq, exp_mrv;
    logic [31:0] ref_mem [int unsigned];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        return ((a - 32'(BASE)) >> 2) & ((32'd1 << (AW - 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                chk("ready",      32'(ready),                  32'(exp_ready));
                chk("sram_we_n",  32'(sram_bus.sram_we_n),     32'(exp_we_n));
                chk("sram_dq_oe", 32'(sram_bus.sram_dq_oe),    32'(exp_oe));
                chk("sram_addr",  32'(sram_bus.sram_addr),     exp_addr);
                chk("sram_dq_out", 32'(sram_bus.sram_dq_out),  exp_dq);
                chk("mem_read_value", mem_read_value,          exp_mrv);
                chk("wb_en",      32'(wb_en),                  32'(wb_en_in));
                chk("mem_r_en",   32'(mem_r_en),               32'(mem_r_en_in));
                chk("dest",       32'(dest),                   32'(dest_in));
                chk("alu_result", alu_result,                  alu_result_in);
                if (!sram_bus.sram_we_n) we_low_cnt++;
                if (!ready) rdy_lo_cnt++;
            end
        end
    end

    task automatic idle(input int n, input logic wb, input logic [3:0] ds, input logic [31:0] a);
        for (int i = 0; i < n; i++) begin
            mem_w_en_in   = 1'b0;
            mem_r_en_in   = 1'b0;
            wb_en_in      = wb;
            dest_in       = ds;
            alu_result_in = a;
            val_rm_in     = $urandom;
            exp_ready     = 1'b1;
            exp_we_n      = 1'b1;
            exp_oe        = 1'b0;
            exp_addr      = 2 * mword(a);
            exp_dq        = 32'h0;
            @(posedge clk); #1;
        end
    endtask

    // Cycle k=0 is the IDLE cycle where the request first appears; k=2*AC+1 is the ready pulse.
    task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input int abort_k);
        logic [31:0] wd, newv;
        logic        lo, hi, wb;
        logic [3:0]  ds;
        int          cnt;
        wd   = mword(a);
        newv = ref_read(wd);
        wb   = 1'($urandom);
        ds   = 4'($urandom);
        for (int k = 0; k <= 2*AC+1; k++) begin
            mem_w_en_in   = w;
            mem_r_en_in   = r;
            alu_result_in = a;
            val_rm_in     = d;
            wb_en_in      = wb;
            dest_in       = ds;
            lo  = (k >= 1) && (k <= AC);
            hi  = (k >= AC+1) && (k <= 2*AC);
            cnt = lo ? k - 1 : k - AC - 1;
            exp_ready = (k == 2*AC+1);
            exp_oe    = w && (lo || hi);
            exp_we_n  = !(w && (lo || hi) && (cnt < AC - 1));
            exp_addr  = hi ? 2*wd + 1 : 2*wd;
            exp_dq    = (w && lo) ? {16'h0, d[15:0]} : (w && hi) ? {16'h0, d[31:16]} : 32'h0;
            if (!w && r && k == AC+1)   exp_mrv[15:0]  = newv[15:0];
            if (!w && r && k == 2*AC+1) exp_mrv[31:16] = newv[31:16];
            if (k == abort_k) rst = 1'b0;
            @(posedge clk); #1;
            if (k == abort_k) begin
                rst     = 1'b1;
                exp_mrv = 32'h0;
                return;
            end
        end
        if (w) ref_mem[wd] = d;
    endtask

    initial begin
        int we0, rl0;
        logic [31:0] a;
        rst       = 1'b0;
        exp_mrv   = 32'h0;
        exp_valid = 1'b1;
        idle(3, 1'b0, 4'h0, 32'd0);
        rst = 1'b1;
        chk("reset_mrv", mem_read_value, 32'h0);

        // No request: ready every cycle, no strobe, pass-through mirrors inputs
        we0 = we_low_cnt;
        idle(4, 1'b1, 4'd5, 32'd7);
        chk("noreq_ready", 32'(ready), 32'd1);
        chk("noreq_dest", 32'(dest), 32'd5);
        chk("noreq_alu", alu_result, 32'd7);
        chk("noreq_strobes", 32'(we_low_cnt - we0), 32'd0);

        // Store then load at 1028
        we0 = we_low_cnt; rl0 = rdy_lo_cnt;
        run_op(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, -1);
        chk("store_we_low_cycles", 32'(we_low_cnt - we0), 32'd2);
        chk("store_freeze_cycles", 32'(rdy_lo_cnt - rl0), 32'd5);
        chk("store_lo_half", 32'(sram_mem[2]), 32'h0000BEEF);
        chk("store_hi_half", 32'(sram_mem[3]), 32'h0000DEAD);
        idle(1, 1'b0, 4'h0, 32'd0);
        run_op(1'b0, 1'b1, 32'd1028, $urandom, -1);
        chk("load_value", mem_read_value, 32'hDEADBEEF);

        // Back-to-back loads from word 0 and word 2
        run_op(1'b1, 1'b0, 32'd1024, 32'h11112222, -1);
        idle(1, 1'b0, 4'h0, 32'd0);
        rl0 = rdy_lo_cnt;
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, -1);
        chk("b2b_first_value", mem_read_value, 32'h11112222);
        run_op(1'b0, 1'b1, 32'd1032, 32'h0, -1);
        chk("b2b_freeze_cycles", 32'(rdy_lo_cnt - rl0), 32'd10);
        chk("b2b_second_value", mem_read_value, 32'h0);

        // Both enables: store wins, load data untouched
        run_op(1'b1, 1'b1, 32'd1024, 32'h0000ABCD, -1);
        chk("both_mrv_kept", mem_read_value, 32'h0);
        chk("both_lo_half", 32'(sram_mem[0]), 32'h0000ABCD);
        chk("both_hi_half", 32'(sram_mem[1]), 32'h0);

        // Wrap past SRAM size with misaligned low bits lands on word 0
        run_op(1'b1, 1'b0, 32'd1024 + (32'd1 << 19) + 32'd3, 32'h12345678, -1);
        chk("wrap_lo_half", 32'(sram_mem[0]), 32'h00005678);
        chk("wrap_hi_half", 32'(sram_mem[1]), 32'h00001234);

        // Reset during WR_HI cnt=0
        run_op(1'b1, 1'b0, 32'd1024 + 32'd400, 32'hCAFEF00D, AC+1);
        chk("abort_we_n", 32'(sram_bus.sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_bus.sram_dq_oe), 32'd0);
        chk("abort_mrv", mem_read_value, 32'h0);
        idle(2, 1'b0, 4'h0, 32'd1024);

        // Random mix over a small window of words so loads hit earlier stores
        for (int i = 0; i < 150; i++) begin
            a = 32'(BASE) + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3))
                + (32'($urandom_range(0, 1)) << 19);
            case ($urandom_range(0, 3))
                0: idle(int'($urandom_range(1, 3)), 1'($urandom), 4'($urandom), $urandom);
                1: run_op(1'b1, 1'b0, a, $urandom, -1);
                2: run_op(1'b0, 1'b1, a, $urandom, -1);
                default: run_op(1'b1, 1'b1, a, $urandom, -1);
            endcase
        end
        idle(2, 1'b0, 4'h0, 32'd0);

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
